// File: rtl/sram_fifo_pkg.sv
// Shared defaults for the SRAM-backed FIFO controller and the s_ram it drives.
package sram_fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 10;
  localparam int DEPTH_DEF  = 50;
  localparam int CNT_W_DEF  = 7;

  // Minimum occupancy counter width able to represent RAM words plus the two staging slots.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 3);
  endfunction

endpackage

// File: rtl/sram_fifo_ctrl_mod_ptr.sv
// Modulo-DEPTH incrementing pointer with synchronous reset and increment enable.
module mod_ptr
  import sram_fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  // Pointer register: wraps from DEPTH-1 back to 0 so it never leaves the used window.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= {ADDR_W{1'b0}};
    end else if (inc) begin
      if (ptr == ADDR_W'(DEPTH - 1)) begin
        ptr <= {ADDR_W{1'b0}};
      end else begin
        ptr <= ptr + ADDR_W'(1);
      end
    end else begin
      ptr <= ptr;
    end
  end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// First-word-fall-through FIFO built on a single-port SRAM; reads take priority
// over writes and each read lands in a registered output stage one cycle later.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wr,
  output logic              ram_cs,
  input  logic [DATA_W-1:0] ram_dout
);

  logic [ADDR_W-1:0] wr_ptr_s;
  logic [ADDR_W-1:0] rd_ptr_s;
  logic [CNT_W-1:0]  ram_cnt_r;
  logic              rd_pend_r;
  logic              rd_gnt_s;
  logic              push_s;

  assign rd_gnt_s = (ram_cnt_r != {CNT_W{1'b0}}) && !rd_pend_r && !out_valid;
  assign in_ready = (ram_cnt_r != CNT_W'(DEPTH)) && !rd_gnt_s;
  assign push_s   = in_valid && in_ready;

  assign count = ram_cnt_r + {{(CNT_W-1){1'b0}}, rd_pend_r} + {{(CNT_W-1){1'b0}}, out_valid};
  assign full  = (ram_cnt_r == CNT_W'(DEPTH));
  assign empty = (count == {CNT_W{1'b0}});

  mod_ptr #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push_s),
    .ptr (wr_ptr_s)
  );

  mod_ptr #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_gnt_s),
    .ptr (rd_ptr_s)
  );

  // RAM port mux: read grant wins, otherwise an accepted push, otherwise idle zeros.
  always_comb begin
    ram_cs   = 1'b0;
    ram_wr   = 1'b0;
    ram_addr = {ADDR_W{1'b0}};
    ram_din  = {DATA_W{1'b0}};
    if (rd_gnt_s) begin
      ram_cs   = 1'b1;
      ram_addr = rd_ptr_s;
    end else if (push_s) begin
      ram_cs   = 1'b1;
      ram_wr   = 1'b1;
      ram_addr = wr_ptr_s;
      ram_din  = in_data;
    end else begin
      ram_cs   = 1'b0;
    end
  end

  // RAM occupancy: push and read grant are mutually exclusive by construction.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_cnt_r <= {CNT_W{1'b0}};
    end else begin
      case ({push_s, rd_gnt_s})
        2'b10:   ram_cnt_r <= ram_cnt_r + CNT_W'(1);
        2'b01:   ram_cnt_r <= ram_cnt_r - CNT_W'(1);
        default: ram_cnt_r <= ram_cnt_r;
      endcase
    end
  end

  // Read-in-flight flag and output stage; capture has priority over pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_r <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= {DATA_W{1'b0}};
    end else begin
      rd_pend_r <= rd_gnt_s;
      if (rd_pend_r) begin
        out_valid <= 1'b1;
        out_data  <= ram_dout;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_data  <= out_data;
      end else begin
        out_valid <= out_valid;
        out_data  <= out_data;
      end
    end
  end

endmodule
